event_priority_encoder: RTL and testbench



---
 rtl/event_priority_encoder.sv | 110 +++++++++++
 tb/tb_event_priority_encoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_priority_encoder.sv
// Registered event priority encoder: latches event pulses and issues them one index at a time over valid/ready.
// Optional round-robin arbitration is enabled by defining EVENT_PRIORITY_ENCODER_ROUND_ROBIN_EN.
module event_priority_encoder #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  output logic [W-1:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         overflow
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [N-1:0] cand;
  logic [N-1:0] grant_mask;
  logic [N-1:0] pending_next;
  logic [W-1:0] sel;
  logic         slot_free;
  logic         grant;
  logic         overflow_next;

`ifdef EVENT_PRIORITY_ENCODER_ROUND_ROBIN_EN
  logic [W-1:0] ptr;
  int           dist;
  int           best_dist;

  // Pick the set bit closest after ptr, wrapping modulo N.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    sel       = '0;
    dist      = 0;
    best_dist = N;
    for (int i = 0; i < N; i++) begin
      dist = i - int'(ptr) - 1;
      if (dist < 0) dist = dist + N;
      if (cand[i] && (dist < best_dist)) begin
        best_dist = dist;
        sel       = W'(i);
      end
    end
  end
`else
  // Descending scan so the lowest set index is the one left in sel.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) sel = W'(i);
    end
  end
`endif

  always_comb begin
    cand       = pending | in;
    slot_free  = (state == EMPTY) || out_ready;
    grant      = slot_free && (cand != '0);
    grant_mask = '0;
    if (grant) grant_mask[sel] = 1'b1;
    pending_next  = cand & ~grant_mask;
    // A re-fired event that is granted this cycle is consumed, not merged.
    overflow_next = |(in & pending & ~grant_mask);
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (cand != '0) state_next = FULL;
      FULL:    if (out_ready && (cand == '0)) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pending_next;
      overflow <= overflow_next;
      if (grant) out <= sel;
    end
  end

`ifdef EVENT_PRIORITY_ENCODER_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ptr <= W'(N - 1);
    else if (grant) ptr <= sel;
  end
`endif

  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_event_priority_encoder.sv
// Directed self-checking bench for event_priority_encoder (N=8); round-robin expectations follow
// EVENT_PRIORITY_ENCODER_ROUND_ROBIN_EN when it is defined.
module tb_event_priority_encoder;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] in = '0;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] pending;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  event_priority_encoder #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .out      (out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1ns so inputs change and outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in        = '0;
    out_ready = 1'b0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out, out_valid, pending, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_state: got out=%0d valid=%0b pending=%h ovf=%0b, expected all 0", out, out_valid, pending, overflow);
    end
    in = 8'h01;
    step();
    out_ready = 1'b0;
    in = 8'h5A;
    step();
    in = '0;
    checks++;
    if (pending !== 8'h5A || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_setup: got pending=%h valid=%0b, expected 5a/1", pending, out_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out, out_valid, pending, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_async: got out=%0d valid=%0b pending=%h ovf=%0b, expected all 0", out, out_valid, pending, overflow);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    in = 8'h20;
    step();
    in = '0;
    checks++;
    if (out !== 3'd5 || out_valid !== 1'b1 || pending !== 8'h00) begin
      errors++;
      $display("FAIL single_grant: got out=%0d valid=%0b pending=%h, expected 5/1/00", out, out_valid, pending);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out !== 3'd5) begin
      errors++;
      $display("FAIL single_drain: got out=%0d valid=%0b, expected 5/0", out, out_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] exp_seq [3] = '{3'd0, 3'd4, 3'd7};
    logic [N-1:0] exp_pend [3] = '{8'h90, 8'h80, 8'h00};
    do_reset();
    in = 8'h91;
    step();
    in = '0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out !== 3'd0 || out_valid !== 1'b1 || pending !== 8'h90) begin
        errors++;
        $display("FAIL simul_hold[%0d]: got out=%0d valid=%0b pending=%h, expected 0/1/90", c, out, out_valid, pending);
      end
      if (c < 2) step();
    end
    out_ready = 1'b1;
    for (int g = 1; g < 3; g++) begin
      step();
      checks++;
      if (out !== exp_seq[g] || out_valid !== 1'b1 || pending !== exp_pend[g]) begin
        errors++;
        $display("FAIL simul_seq[%0d]: got out=%0d valid=%0b pending=%h, expected %0d/1/%h", g, out, out_valid, pending, exp_seq[g], exp_pend[g]);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_drain: got valid=%0b, expected 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    in = 8'h02;
    step();
    step();
    checks++;
    if (out !== 3'd1 || out_valid !== 1'b1 || pending !== 8'h02 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_setup: got out=%0d valid=%0b pending=%h ovf=%0b, expected 1/1/02/0", out, out_valid, pending, overflow);
    end
    step();
    in = '0;
    checks++;
    if (pending !== 8'h02 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pulse: got pending=%h ovf=%0b, expected 02/1", pending, overflow);
    end
    step();
    checks++;
    if (overflow !== 1'b0 || pending !== 8'h02) begin
      errors++;
      $display("FAIL ovf_one_cycle: got pending=%h ovf=%0b, expected 02/0", pending, overflow);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out !== 3'd1 || out_valid !== 1'b1 || pending !== 8'h00) begin
      errors++;
      $display("FAIL ovf_regrant: got out=%0d valid=%0b pending=%h, expected 1/1/00", out, out_valid, pending);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_no_extra: got valid=%0b, expected 0", out_valid);
    end
  endtask

  task automatic test_same_bit();
    do_reset();
    in = 8'h01;
    step();
    step();
    out_ready = 1'b1;
    step();
    in = '0;
    checks++;
    if (out !== 3'd0 || out_valid !== 1'b1 || pending !== 8'h00 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL same_bit_grant: got out=%0d valid=%0b pending=%h ovf=%0b, expected 0/1/00/0", out, out_valid, pending, overflow);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    in = 8'hFF;
    for (int i = 0; i < N; i++) begin
      step();
      in = '0;
      checks++;
      if (out !== W'(i) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b[%0d]: got out=%0d valid=%0b, expected %0d/1", i, out, out_valid, i);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      errors++;
      $display("FAIL b2b_drain: got valid=%0b pending=%h, expected 0/00", out_valid, pending);
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] first;
    logic [W-1:0] second;
    do_reset();
    out_ready = 1'b1;
    in = 8'h08;
    step();
    in = '0;
    step();
    in = 8'h09;
    step();
    in = '0;
    checks++;
    if (out !== 3'd0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rr_after3_first: got out=%0d valid=%0b, expected 0/1", out, out_valid);
    end
    step();
    checks++;
    if (out !== 3'd3 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rr_after3_second: got out=%0d valid=%0b, expected 3/1", out, out_valid);
    end
    do_reset();
    out_ready = 1'b1;
    in = 8'h01;
    step();
    in = '0;
    step();
    in = 8'h09;
`ifdef EVENT_PRIORITY_ENCODER_ROUND_ROBIN_EN
    first  = 3'd3;
    second = 3'd0;
`else
    first  = 3'd0;
    second = 3'd3;
`endif
    step();
    in = '0;
    checks++;
    if (out !== first || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rr_after0_first: got out=%0d valid=%0b, expected %0d/1", out, out_valid, first);
    end
    step();
    checks++;
    if (out !== second || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rr_after0_second: got out=%0d valid=%0b, expected %0d/1", out, out_valid, second);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_overflow();
    test_same_bit();
    test_back_to_back();
    test_round_robin();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
